alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Pipelined, opcode-selected integer ALU with valid/ready flow control and status flags.
//  It replaces the all-outputs-at-once combinational ALU, and sits between an operand
//  issue stage and a result writeback stage.
//  Computes one selected op per accepted transaction. A caller tag is carried with each
//  transaction. Latency is fixed and set by a parameter.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width, >= 2
//  LATENCY     2   pipeline register stages from accept to out_valid, 1..4
//  TAG_WIDTH   4   width of opaque tag carried alongside each transaction, >= 1
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  in_valid   in   1           operands/op presented
//  in_ready   out  1           ALU can accept this cycle
//  op         in   3           0 ADD, 1 SUB, 2 NOT_A, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL
//  a          in   DATA_WIDTH  operand A
//  b          in   DATA_WIDTH  operand B (shift amount for SLL/SRL)
//  in_tag     in   TAG_WIDTH   caller tag
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  result     out  DATA_WIDTH  op result
//  out_tag    out  TAG_WIDTH   tag of this result
//  flag_z     out  1           result == 0
//  flag_n     out  1           result[DATA_WIDTH-1]
//  flag_c     out  1           ADD: carry-out; SUB: borrow (a < b unsigned); else 0
//  flag_v     out  1           ADD/SUB: signed overflow; else 0
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): all stage valids = 0.
//    out_valid = 0; result, out_tag and all flags = 0.
//  - Transfer rules: input handshake when in_valid && in_ready; output when out_valid && out_ready.
//  - Pipeline: LATENCY stages, each with a valid bit. Global stall: advance = !out_valid || out_ready.
//    in_ready = advance (combinational from out_ready; no combinational path from in_valid).
//  - When advance, every stage shifts forward. Stage 0 loads (in_valid && in_ready).
//  - Bubbles are not collapsed while stalled; the whole pipe freezes, contents held.
//  - Latency: a transaction accepted at edge N gives out_valid high after edge N+LATENCY-1,
//    when there is no stall. Throughput is 1/cycle when out_ready is held high.
//  - Compute point: the op is computed combinationally from the stage-0 inputs and registered
//    into stage 0. Later stages are pure delay. Flags are registered with the result.
//  - Arithmetic: ADD/SUB use a DATA_WIDTH+1 bit sum; the result is the low DATA_WIDTH bits.
//    flag_c = bit DATA_WIDTH for ADD and the inverted bit for SUB (borrow).
//  - flag_v for ADD: operand signs are equal and the result sign differs.
//    flag_v for SUB: operand signs differ and the result sign differs from a.
//  - NOT_A ignores b. AND/OR/XOR are bitwise.
//  - SLL/SRL are logical shifts by the full unsigned value of b. If b >= DATA_WIDTH, result = 0.
//  - flag_z and flag_n are valid for all ops.
//  - Output regs hold their value while out_valid && !out_ready.
//  - Output values are don't-care when out_valid = 0; the bench must not check them.
//  - Simultaneous output pop and input accept in the same cycle is legal and loses nothing.
//  - Reset mid-operation: all in-flight transactions are discarded. No partial output after release.
//  - op, a, b and in_tag are sampled only on an input handshake.
// TESTING  (DATA_WIDTH=8, LATENCY=2, TAG_WIDTH=4 unless noted)
//  - Reset, then idle: out_valid=0, result=0, in_ready=1. Assert reset while 2 ops are in flight
//    -> out_valid drops immediately, nothing emerges after release.
//  - ADD a=0xFF b=0x01 tag=3 -> 2 edges later result=0x00, z=1, c=1, v=0, n=0, out_tag=3.
//    ADD 0x7F+0x01 -> 0x80, v=1, n=1, c=0.
//  - SUB a=0x03 b=0x05 -> result=0xFE, c=1 (borrow), n=1, v=0.
//    SUB 0x80-0x01 -> 0x7F, v=1, c=0.
//  - Shifts: SLL a=0x81 b=1 -> 0x02. SRL a=0x81 b=7 -> 0x01. SLL a=0xFF b=8 -> 0x00, z=1.
//    NOT_A a=0x0F -> 0xF0.
//  - Back-to-back stream of 6 ops with out_ready=1 -> 6 results on consecutive cycles, in order,
//    tags 0..5 intact.
//  - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once the pipe is full.
//    result/tag stable. Releasing -> all held results emerge in order, no drop or duplicate.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined eight-op integer ALU with valid/ready flow control and status flags.
// The op is evaluated ahead of stage 0; later stages only delay the registered result.
module alu_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam int unsigned LAST = LATENCY - 1;
  localparam int unsigned MSB  = DATA_WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] result;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  z;
    logic                  n;
    logic                  c;
    logic                  v;
  } stage_t;

  stage_t                stage_d;
  stage_t                stage_q [LATENCY];
  logic                  advance;
  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  c_d;
  logic                  v_d;
  logic                  shift_oob;

  // Whole pipe moves or freezes together; the output slot gates everything.
  assign advance  = !stage_q[LAST].valid || out_ready;
  assign in_ready = advance;

  // Subtraction as a + ~b + 1 so bit DATA_WIDTH is the inverted borrow.
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign shift_oob = b >= DATA_WIDTH'(DATA_WIDTH);

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = add_full[MSB:0];
        c_d   = add_full[DATA_WIDTH];
        v_d   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_d = sub_full[MSB:0];
        c_d   = !sub_full[DATA_WIDTH];
        v_d   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      OP_NOT: res_d = ~a;
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_SLL: res_d = shift_oob ? '0 : (a << b);
      OP_SRL: res_d = shift_oob ? '0 : (a >> b);
      default: res_d = '0;
    endcase
  end

  assign stage_d = '{valid:  in_valid,
                     result: res_d,
                     tag:    in_tag,
                     z:      (res_d == '0),
                     n:      res_d[MSB],
                     c:      c_d,
                     v:      v_d};

  // Stage 0 captures operands only on a handshake; later stages are pure delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else if (advance) begin
      if (in_valid) begin
        stage_q[0] <= stage_d;
      end else begin
        stage_q[0].valid <= 1'b0;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[LAST].valid;
  assign result    = stage_q[LAST].result;
  assign out_tag   = stage_q[LAST].tag;
  assign flag_z    = stage_q[LAST].z;
  assign flag_n    = stage_q[LAST].n;
  assign flag_c    = stage_q[LAST].c;
  assign flag_v    = stage_q[LAST].v;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at DATA_WIDTH=8, LATENCY=2, TAG_WIDTH=4.
module tb_alu_pipe;

  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned TW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [TW-1:0] out_tag;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;  // {z, n, c, v}
  } vec_t;

  alu_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Issue one op into an empty pipe and wait (bounded) for its result.
  task automatic send_op(input logic [2:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic [3:0] tag_v, output logic [7:0] res_o,
                         output logic [3:0] tag_o, output logic [3:0] flags_o, output int lat);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = op_v; a = a_v; b = b_v; in_tag = tag_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res_o   = result;
    tag_o   = out_tag;
    flags_o = {flag_z, flag_n, flag_c, flag_v};
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++;
    if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_arith();
    vec_t       v [6];
    logic [7:0] r;
    logic [3:0] t;
    logic [3:0] f;
    int         lat;
    v[0] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010};
    v[1] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    v[2] = '{3'd0, 8'h80, 8'h80, 8'h00, 4'b1011};
    v[3] = '{3'd1, 8'h03, 8'h05, 8'hFE, 4'b0110};
    v[4] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
    v[5] = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      send_op(v[i].op, v[i].a, v[i].b, 4'(i + 3), r, t, f, lat);
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      checks++;
      if (r !== v[i].res) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", i, r, v[i].res); end
      checks++;
      if (f !== v[i].flags) begin errors++; $display("FAIL arith_flags[%0d]: got %b expected %b", i, f, v[i].flags); end
      checks++;
      if (t !== 4'(i + 3)) begin errors++; $display("FAIL arith_tag[%0d]: got %h expected %h", i, t, 4'(i + 3)); end
    end
  endtask

  task automatic test_logic_shift();
    vec_t       v [9];
    logic [7:0] r;
    logic [3:0] t;
    logic [3:0] f;
    int         lat;
    v[0] = '{3'd2, 8'h0F, 8'h55, 8'hF0, 4'b0100};
    v[1] = '{3'd3, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    v[2] = '{3'd4, 8'hF0, 8'h0F, 8'hFF, 4'b0100};
    v[3] = '{3'd5, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    v[4] = '{3'd6, 8'h81, 8'h01, 8'h02, 4'b0000};
    v[5] = '{3'd7, 8'h81, 8'h07, 8'h01, 4'b0000};
    v[6] = '{3'd6, 8'hFF, 8'h08, 8'h00, 4'b1000};
    v[7] = '{3'd7, 8'h80, 8'hC8, 8'h00, 4'b1000};
    v[8] = '{3'd7, 8'h80, 8'h07, 8'h01, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      send_op(v[i].op, v[i].a, v[i].b, 4'(15 - i), r, t, f, lat);
      checks++;
      if (r !== v[i].res) begin errors++; $display("FAIL logic_result[%0d]: got %h expected %h", i, r, v[i].res); end
      checks++;
      if (f !== v[i].flags) begin errors++; $display("FAIL logic_flags[%0d]: got %b expected %b", i, f, v[i].flags); end
      checks++;
      if (t !== 4'(15 - i)) begin errors++; $display("FAIL logic_tag[%0d]: got %h expected %h", i, t, 4'(15 - i)); end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    op = 3'd0; a = 8'h01; b = 8'h01; in_tag = 4'h7;
    @(posedge clk); #1;
    a = 8'h02; in_tag = 4'h8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_loaded: got %b expected 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_drop: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midflight_leak: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rq [$];
    logic [3:0] tq [$];
    int         cq [$];
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        in_valid = 1'b1; op = 3'd0; a = 8'(c); b = 8'h10; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        rq.push_back(result); tq.push_back(out_tag); cq.push_back(c);
      end
    end
    checks++;
    if (rq.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", rq.size()); end
    for (int k = 0; k < 6 && k < rq.size(); k++) begin
      checks++;
      if (rq[k] !== 8'(8'h10 + k) || tq[k] !== 4'(k) || cq[k] != cq[0] + k) begin
        errors++;
        $display("FAIL b2b_item[%0d]: got res=%h tag=%h cyc=%0d expected res=%h tag=%h cyc=%0d",
                 k, rq[k], tq[k], cq[k], 8'(8'h10 + k), 4'(k), cq[0] + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int         k    = 0;
    int         npop = 0;
    bit         acc;
    logic [7:0] held_r = '0;
    logic [3:0] held_t = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      if (k < 4) begin
        in_valid = 1'b1; op = 3'd5; a = 8'h5A; b = 8'(k); in_tag = 4'(8 + k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c < 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stall[%0d]: got in_ready=%b out_valid=%b expected 0/1", c, in_ready, out_valid);
        end
        if (c == 2) begin
          held_r = result; held_t = out_tag;
        end else begin
          checks++;
          if (result !== held_r || out_tag !== held_t) begin
            errors++; $display("FAIL bp_hold[%0d]: got %h/%h expected %h/%h", c, result, out_tag, held_r, held_t);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (npop >= 4) begin
          errors++; $display("FAIL bp_extra: got tag=%h expected no output", out_tag);
        end else if (result !== (8'h5A ^ 8'(npop)) || out_tag !== 4'(8 + npop)) begin
          errors++; $display("FAIL bp_pop[%0d]: got %h/%h expected %h/%h",
                             npop, result, out_tag, 8'h5A ^ 8'(npop), 4'(8 + npop));
        end
        npop++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    checks++;
    if (npop != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", npop); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_reset_midflight();
    test_back_to_back();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
